instruction_fetch_unit: RTL

- Fetch stage directly downstream of the 16-bit program counter.
- Gates the PC address bus onto the program-memory port (Harvard instruction side) and runs a req/ack transaction to program memory.
- Latches the returned word into a one-entry instruction register and offers it to the decoder with a valid/ready handshake.
- Issues one count_enable pulse to the PC per fetch; handles jump flushes and memory timeouts.

---
 rtl/instruction_fetch_unit.sv | 96 +++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC-driven fetch with req/ack program-memory port, one-entry IR and timeout
module instruction_fetch_unit #(
  parameter int word_size = 16,
  parameter int ack_timeout = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [word_size-1:0] pc_address,
  output logic                 pc_load_address,
  output logic                 pc_count_enable,
  input  logic                 flush,
  output logic                 imem_req,
  output logic [word_size-1:0] imem_addr,
  input  logic [word_size-1:0] imem_rdata,
  input  logic                 imem_ack,
  output logic [word_size-1:0] instruction,
  output logic [word_size-1:0] instr_address,
  output logic                 ir_valid,
  input  logic                 ir_ready,
  output logic                 fetch_error
);
  typedef enum logic [2:0] {S_ISSUE, S_WAIT, S_HOLD, S_DRAIN, S_ERROR} state_t;
  state_t state;
  logic inc_pending;
  logic [7:0] cnt;
  logic timed_out;
  assign timed_out = cnt == 8'(ack_timeout - 1);
  // PC strobes: load while issuing, a single increment in the first hold cycle unless a jump lands
  always_comb begin
    pc_load_address = ~reset & (state == S_ISSUE);
    pc_count_enable = ~reset & (state == S_HOLD) & inc_pending & ~flush;
  end
  // fetch sequencer: issue, wait for ack, hold for decoder, drain abandoned requests, trap on timeout
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_ISSUE;
      inc_pending <= 1'b0;
      cnt <= 8'd0;
      imem_req <= 1'b0;
      imem_addr <= '0;
      instruction <= '0;
      instr_address <= '0;
      ir_valid <= 1'b0;
      fetch_error <= 1'b0;
    end else begin
      case (state)
        S_ISSUE:
          if (!flush) begin
            imem_addr <= pc_address;
            imem_req <= 1'b1;
            cnt <= 8'd0;
            state <= S_WAIT;
          end
        S_WAIT:
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (flush) state <= S_ISSUE;
            else begin
              instruction <= imem_rdata;
              instr_address <= imem_addr;
              ir_valid <= 1'b1;
              inc_pending <= 1'b1;
              state <= S_HOLD;
            end
          end else if (timed_out) begin
            imem_req <= 1'b0;
            fetch_error <= 1'b1;
            state <= S_ERROR;
          end else begin
            cnt <= cnt + 8'd1;
            if (flush) state <= S_DRAIN;
          end
        S_HOLD: begin
          inc_pending <= 1'b0;
          if (flush || ir_ready) begin
            ir_valid <= 1'b0;
            state <= S_ISSUE;
          end
        end
        S_DRAIN:
          if (imem_ack) begin
            imem_req <= 1'b0;
            state <= S_ISSUE;
          end else if (timed_out) begin
            imem_req <= 1'b0;
            fetch_error <= 1'b1;
            state <= S_ERROR;
          end else cnt <= cnt + 8'd1;
        default: begin
          imem_req <= 1'b0;
          ir_valid <= 1'b0;
          fetch_error <= 1'b1;
        end
      endcase
    end
endmodule
